// File: rtl/gcd_pkg.sv
// Shared GCD board definitions: controller states, LED codes, default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gcd_pkg;

    localparam int GCD_WIDTH          = 16;
    localparam int GCD_TIMEOUT_CYCLES = 131072;

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_RUN,
        ST_SHOW,
        ST_ERR
    } gcd_state_t;

    localparam logic [3:0] LED_WAIT_A = 4'b0001;
    localparam logic [3:0] LED_WAIT_B = 4'b0010;
    localparam logic [3:0] LED_RUN    = 4'b0100;
    localparam logic [3:0] LED_SHOW   = 4'b1000;
    localparam logic [3:0] LED_ERR    = 4'b1111;

    function automatic logic [3:0] led_of(input gcd_state_t s);
        case (s)
            ST_WAIT_A: led_of = LED_WAIT_A;
            ST_WAIT_B: led_of = LED_WAIT_B;
            ST_RUN:    led_of = LED_RUN;
            ST_SHOW:   led_of = LED_SHOW;
            default:   led_of = LED_ERR;
        endcase
    endfunction

endpackage

// File: rtl/gcd_entry_sequencer_btn_conditioner.sv
// Button conditioner: 2-flop sync, optional counter debounce (GCD_DEBOUNCE_EN), rising-edge press pulse.
// Latency: press valid during the cycle ending on the 3rd edge after the raw rise (plus DEBOUNCE_CYCLES when debounced).
// Backpressure: none; the pulse is one cycle wide and is lost if the consumer ignores it.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef GCD_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          stable_q;
    logic          press_q;

    // Counter runs only while the synced level disagrees with the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q    <= '0;
                stable_q <= sync2_q;
                press_q  <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;
`else
    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= sync2_q;
        end
    end

    assign press_o = sync2_q & ~level_q;
`endif

endmodule

// File: rtl/gcd_entry_sequencer.sv
// Board GCD controller: captures A/B on Center presses, runs the datapath over start/done, shows result (GCD_DEBOUNCE_EN selects debounce).
// Latency: state/capture on the press edge; Gcd lands the edge after gcd_done; 2 cycles over datapath latency.
// Backpressure: presses outside WAIT_A/WAIT_B/SHOW/ERR are dropped; RUN gives up after TIMEOUT_CYCLES.
module gcd_entry_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH           = GCD_WIDTH,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES  = GCD_TIMEOUT_CYCLES
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [WIDTH-1:0] SW,
    input  logic             Center,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Gcd,
    output logic [3:0]       LED
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic             press;
    gcd_state_t       state_q;
    logic [WIDTH-1:0] a_q, b_q, gcd_q;
    logic             start_q;
    logic [3:0]       led_q;
    logic [TW-1:0]    tmo_q;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (CLK100MHZ),
        .rst_n  (CPU_RESETN),
        .btn_i  (Center),
        .press_o(press)
    );

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= ST_WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            start_q <= 1'b0;
            led_q   <= LED_WAIT_A;
            tmo_q   <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_WAIT_A: if (press) begin
                    a_q     <= SW;
                    b_q     <= '0;
                    gcd_q   <= '0;
                    state_q <= ST_WAIT_B;
                    led_q   <= led_of(ST_WAIT_B);
                end
                // A zero operand short-circuits: gcd(x,0)=x, never start the datapath.
                ST_WAIT_B: if (press) begin
                    b_q <= SW;
                    if (a_q == '0 || SW == '0) begin
                        gcd_q   <= a_q | SW;
                        state_q <= ST_SHOW;
                        led_q   <= led_of(ST_SHOW);
                    end else begin
                        start_q <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= ST_RUN;
                        led_q   <= led_of(ST_RUN);
                    end
                end
                // start_q marks the first RUN cycle, where done is not trusted.
                ST_RUN: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (!start_q && gcd_done) begin
                        gcd_q   <= gcd_result;
                        state_q <= ST_SHOW;
                        led_q   <= led_of(ST_SHOW);
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        gcd_q   <= '0;
                        state_q <= ST_ERR;
                        led_q   <= led_of(ST_ERR);
                    end
                end
                ST_SHOW, ST_ERR: if (press) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    gcd_q   <= '0;
                    state_q <= ST_WAIT_A;
                    led_q   <= led_of(ST_WAIT_A);
                end
                default: begin
                    state_q <= ST_WAIT_A;
                    led_q   <= led_of(ST_WAIT_A);
                end
            endcase
        end
    end

    assign gcd_start = start_q;
    assign gcd_a     = a_q;
    assign gcd_b     = b_q;
    assign A         = a_q;
    assign B         = b_q;
    assign Gcd       = gcd_q;
    assign LED       = led_q;

endmodule

// File: tb/tb_gcd_entry_sequencer.sv
// Bench for gcd_entry_sequencer: random operand pairs against a Euclid reference, scoreboarded on SHOW/ERR entry.
module tb_gcd_entry_sequencer;

    localparam int W   = 16;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw = '0;
    logic         center = 1'b0;
    logic         gcd_done = 1'b0;
    logic [W-1:0] gcd_result = '0;
    logic         gcd_start;
    logic [W-1:0] gcd_a, gcd_b, a_o, b_o, gcd_o;
    logic [3:0]   led;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] gcd;
        logic [3:0]   led;
        int           run_len;
    } exp_t;

    exp_t       exp_q[$];
    int         start_cnt = 0;
    int         run_cnt = 0;
    logic [3:0] led_prev = 4'b0001;
    bit         dp_never = 1'b0;
    bit         dp_spur = 1'b0;
    int         dp_lat = 20;

    always #5 clk = ~clk;

    gcd_entry_sequencer #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .SW        (sw),
        .Center    (center),
        .gcd_done  (gcd_done),
        .gcd_result(gcd_result),
        .gcd_start (gcd_start),
        .gcd_a     (gcd_a),
        .gcd_b     (gcd_b),
        .A         (a_o),
        .B         (b_o),
        .Gcd       (gcd_o),
        .LED       (led)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        int p = int'(x);
        int q = int'(y);
        int t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return W'(p);
    endfunction

    // Behavioural datapath: optional bogus done in the start cycle, real done dp_lat cycles later.
    initial begin
        logic [W-1:0] ra, rb;
        forever begin
            @(negedge clk);
            if (gcd_start === 1'b1) begin
                ra = gcd_a;
                rb = gcd_b;
                if (dp_spur) begin
                    gcd_done   = 1'b1;
                    gcd_result = 16'hDEAD;
                end
                @(negedge clk);
                gcd_done = 1'b0;
                if (!dp_never) begin
                    repeat (dp_lat - 1) @(negedge clk);
                    gcd_done   = 1'b1;
                    gcd_result = ref_gcd(ra, rb);
                    @(negedge clk);
                    gcd_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pops an expectation each time the DUT enters SHOW or ERR.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (gcd_start === 1'b1) start_cnt++;
            if (led == 4'b0100) run_cnt = (led_prev == 4'b0100) ? run_cnt + 1 : 1;
            if ((led == 4'b1000 || led == 4'b1111) && led != led_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: actual led=%0h gcd=%0h required no result", led, gcd_o);
                end else begin
                    e = exp_q.pop_front();
                    check("result_gcd", 32'(gcd_o), 32'(e.gcd));
                    check("result_led", 32'(led), 32'(e.led));
                    if (e.run_len >= 0) check("run_cycles", run_cnt, e.run_len);
                end
            end
        end
        led_prev = led;
    end

    task automatic press(input logic [W-1:0] v);
        sw = v;
        @(negedge clk);
        center = 1'b1;
        repeat (4) @(negedge clk);
        center = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_led(input logic [3:0] tgt, input int budget, input string name);
        int n = 0;
        while (led !== tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(led), 32'(tgt));
    endtask

    task automatic clear_and_check();
        press(16'h1234);
        check("clear_led", 32'(led), 32'h1);
        check("clear_A", 32'(a_o), 32'h0);
        check("clear_B", 32'(b_o), 32'h0);
        check("clear_Gcd", 32'(gcd_o), 32'h0);
    endtask

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                           input bit spur, input bit mid_press);
        exp_t e;
        int   s0;
        bit   zero;
        dp_lat   = lat;
        dp_spur  = spur;
        dp_never = 1'b0;
        zero     = (a == '0) || (b == '0);
        press(a);
        check("waitb_led", 32'(led), 32'h2);
        check("capture_A", 32'(a_o), 32'(a));
        check("waitb_B", 32'(b_o), 32'h0);
        s0        = start_cnt;
        e.gcd     = ref_gcd(a, b);
        e.led     = 4'b1000;
        e.run_len = zero ? -1 : lat + 1;
        exp_q.push_back(e);
        press(b);
        if (!zero) begin
            check("run_led", 32'(led), 32'h4);
            check("gcd_a", 32'(gcd_a), 32'(a));
            check("gcd_b", 32'(gcd_b), 32'(b));
            if (mid_press) press(16'hFFFF);
        end
        wait_led(4'b1000, 200, "show_reached");
        check("start_pulses", start_cnt - s0, zero ? 0 : 1);
        check("hold_A", 32'(a_o), 32'(a));
        check("hold_B", 32'(b_o), 32'(b));
        clear_and_check();
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        exp_t e;
        int   k;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clk);
        check("reset_led", 32'(led), 32'h1);
        check("reset_A", 32'(a_o), 32'h0);
        check("reset_B", 32'(b_o), 32'h0);
        check("reset_Gcd", 32'(gcd_o), 32'h0);
        check("reset_start", 32'(gcd_start), 32'h0);
        check("reset_gcd_a", 32'(gcd_a), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(16'h00F0, 16'h000F, 20, 1'b0, 1'b0);
        run_txn(16'h0000, 16'h0024, 20, 1'b0, 1'b0);
        run_txn(16'h0000, 16'h0000, 20, 1'b0, 1'b0);
        run_txn(16'h0031, 16'h0000, 20, 1'b0, 1'b0);
        run_txn(16'h0023, 16'h0005, 40, 1'b1, 1'b1);

        // Datapath never answers: RUN must give up after TMO cycles.
        dp_never  = 1'b1;
        dp_spur   = 1'b0;
        press(16'h0030);
        e.gcd     = '0;
        e.led     = 4'b1111;
        e.run_len = TMO;
        exp_q.push_back(e);
        press(16'h0012);
        wait_led(4'b1111, 200, "err_reached");
        clear_and_check();
        dp_never = 1'b0;

        for (int i = 0; i < 12; i++) begin
            k  = $urandom_range(1, 200);
            ra = ($urandom_range(0, 5) == 0) ? 16'h0 : W'(k * $urandom_range(1, 300));
            rb = ($urandom_range(0, 5) == 0) ? 16'h0 : W'(k * $urandom_range(1, 300));
            run_txn(ra, rb, $urandom_range(10, 50), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of RUN; the datapath's late done must be ignored.
        dp_lat  = 20;
        dp_spur = 1'b0;
        press(16'h0100);
        press(16'h0080);
        check("midrst_in_run", 32'(led), 32'h4);
        rst_n = 1'b0;
        #1;
        check("midrst_led", 32'(led), 32'h1);
        check("midrst_A", 32'(a_o), 32'h0);
        check("midrst_start", 32'(gcd_start), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_led_after_done", 32'(led), 32'h1);
        check("midrst_gcd_after_done", 32'(gcd_o), 32'h0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
